// File: rtl/issue_pkg.sv
// Shared constants and types for the issue grant pipeline.
//   IQ_SIZE         : issue-queue entries (one-hot grant width)
//   IQ_IDX_W        : encoded IQ index width
//   iq_idx_t        : encoded IQ index type
//   grant_fifo_st_e : occupancy state of the 2-entry grant skid FIFO
package issue_pkg;

  localparam int IQ_SIZE  = 32;
  localparam int IQ_IDX_W = $clog2(IQ_SIZE);

  typedef logic [IQ_IDX_W-1:0] iq_idx_t;

  typedef enum logic [1:0] {
    GF_EMPTY = 2'd0,
    GF_ONE   = 2'd1,
    GF_TWO   = 2'd2
  } grant_fifo_st_e;

endpackage

// File: rtl/grant_index_encoder.sv
// One-hot grant vector to IQ index encoder (combinational).
// If more than one bit is set, the lowest set bit wins so behaviour stays deterministic.
// Ports:
//   vec_i   in  IQ_SIZE   grant vector
//   idx_o   out IQ_IDX_W  index of lowest set bit (0 when vec_i is zero)
//   any_o   out 1         at least one bit set
//   multi_o out 1         more than one bit set
module grant_index_encoder
  import issue_pkg::*;
#(
  parameter int IQ_SIZE  = issue_pkg::IQ_SIZE,
  parameter int IQ_IDX_W = $clog2(IQ_SIZE)
) (
  input  logic [IQ_SIZE-1:0]  vec_i,
  output logic [IQ_IDX_W-1:0] idx_o,
  output logic                any_o,
  output logic                multi_o
);

  // Scan from the top down so the last (lowest) hit overrides.
  always_comb begin
    idx_o = '0;
    for (int i = IQ_SIZE - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = i[IQ_IDX_W-1:0];
    end
  end

  assign any_o   = |vec_i;
  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi_o = |(vec_i & (vec_i - {{(IQ_SIZE-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/issue_grant_pipe.sv
// Issue grant pipeline for one FU lane: encodes the select-tree grant to an IQ index,
// buffers it in a 2-entry skid FIFO toward register read and backpressures the root
// select stage through grant_en_o.
// Optional feature macro: ISSUE_GRANT_ONEHOT_CHK_EN (sticky multi-hot grant error).
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   grant_vec_i      one-hot (or zero) grant from select tree
//   grant_en_o       slot available (to root select stage grant_i)
//   iq_ack_o         accepted grant echoed back to the IQ
//   flush_i          discard all buffered grants
//   valid_o, idx_o   head of FIFO toward register read
//   ready_i          register read accepts head
//   stall_cnt_o      saturating count of valid_o & !ready_i cycles
//   err_o            sticky multi-hot grant error (0 without the macro)
//
// state    | meaning
// GF_EMPTY | no buffered grant, valid_o=0
// GF_ONE   | head holds one grant
// GF_TWO   | head and skid both hold grants, grant_en_o=0
module issue_grant_pipe
  import issue_pkg::*;
#(
  parameter int IQ_SIZE    = issue_pkg::IQ_SIZE,
  parameter int IQ_IDX_W   = $clog2(IQ_SIZE),
  parameter int PERF_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IQ_SIZE-1:0]    grant_vec_i,
  output logic                  grant_en_o,
  output logic [IQ_SIZE-1:0]    iq_ack_o,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic [IQ_IDX_W-1:0]   idx_o,
  input  logic                  ready_i,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic                  err_o
);

  grant_fifo_st_e        state_q, state_d;
  logic [IQ_IDX_W-1:0]   head_q, head_d;
  logic [IQ_IDX_W-1:0]   skid_q, skid_d;
  logic [PERF_CNT_W-1:0] stall_q;

  logic [IQ_IDX_W-1:0] enc_idx;
  logic                enc_any;
  logic                enc_multi;
  logic                accept;
  logic                pop;

  grant_index_encoder #(
    .IQ_SIZE  (IQ_SIZE),
    .IQ_IDX_W (IQ_IDX_W)
  ) u_enc (
    .vec_i   (grant_vec_i),
    .idx_o   (enc_idx),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  // Backpressure from registered state only, so no ready_i -> grant_en_o path.
  assign grant_en_o = (state_q != GF_TWO) & ~flush_i;
  assign accept     = grant_en_o & enc_any;
  assign iq_ack_o   = accept ? grant_vec_i : '0;
  assign valid_o    = (state_q != GF_EMPTY);
  assign idx_o      = head_q;
  assign pop        = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = GF_EMPTY;
    end else begin
      unique case (state_q)
        GF_EMPTY: begin
          if (accept) begin
            state_d = GF_ONE;
            head_d  = enc_idx;
          end
        end
        GF_ONE: begin
          if (accept && !pop) begin
            state_d = GF_TWO;
            skid_d  = enc_idx;
          end else if (pop && !accept) begin
            state_d = GF_EMPTY;
          end else if (accept && pop) begin
            head_d  = enc_idx;
          end
        end
        GF_TWO: begin
          if (pop) begin
            state_d = GF_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = GF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GF_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (valid_o && !ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_o = stall_q;

`ifdef ISSUE_GRANT_ONEHOT_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (grant_en_o && enc_multi) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_grant_onehot: assert (!(grant_en_o && enc_multi));
    end
  end

  assign err_o = err_q;
`else
  logic unused_multi;
  assign unused_multi = enc_multi;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_issue_grant_pipe.sv
module tb_issue_grant_pipe;

  localparam int IQ_SIZE    = 32;
  localparam int IQ_IDX_W   = 5;
  localparam int PERF_CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [IQ_SIZE-1:0]    grant_vec_i;
  logic                  grant_en_o;
  logic [IQ_SIZE-1:0]    iq_ack_o;
  logic                  flush_i;
  logic                  valid_o;
  logic [IQ_IDX_W-1:0]   idx_o;
  logic                  ready_i;
  logic [PERF_CNT_W-1:0] stall_cnt_o;
  logic                  err_o;

  int errors = 0;
  int checks = 0;
  logic exp_err;

  always #5 clk = ~clk;

  issue_grant_pipe #(
    .IQ_SIZE    (IQ_SIZE),
    .IQ_IDX_W   (IQ_IDX_W),
    .PERF_CNT_W (PERF_CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .grant_vec_i (grant_vec_i),
    .grant_en_o  (grant_en_o),
    .iq_ack_o    (iq_ack_o),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .idx_o       (idx_o),
    .ready_i     (ready_i),
    .stall_cnt_o (stall_cnt_o),
    .err_o       (err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef ISSUE_GRANT_ONEHOT_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1; grant_vec_i = '0; flush_i = 1'b0; ready_i = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_idx", 64'(idx_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_gen", 64'(grant_en_o), 64'd1);

    // 1: single grant, latency one cycle
    grant_vec_i = 32'h1 << 5; #1;
    chk("t1_ack", 64'(iq_ack_o), 64'h20);
    step();
    grant_vec_i = '0; #1;
    chk("t1_valid", 64'(valid_o), 64'd1);
    chk("t1_idx", 64'(idx_o), 64'd5);
    step();
    chk("t1_empty", 64'(valid_o), 64'd0);

    // 2: fill to two, backpressure, drain in order
    ready_i = 1'b0; grant_vec_i = 32'h1 << 3;
    step();
    grant_vec_i = 32'h1 << 9; #1;
    chk("t2_ack9", 64'(iq_ack_o), 64'h200);
    step();                                   // stall=1
    grant_vec_i = 32'h1 << 12; #1;
    chk("t2_gen_full", 64'(grant_en_o), 64'd0);
    chk("t2_noack12", 64'(iq_ack_o), 64'd0);
    chk("t2_idx3", 64'(idx_o), 64'd3);
    step();                                   // stall=2
    grant_vec_i = '0; ready_i = 1'b1; #1;
    chk("t2_head3", 64'(idx_o), 64'd3);
    step();
    chk("t2_idx9", 64'(idx_o), 64'd9);
    chk("t2_gen_back", 64'(grant_en_o), 64'd1);
    step();
    chk("t2_drained", 64'(valid_o), 64'd0);
    chk("t2_stall", 64'(stall_cnt_o), 64'd2);

    // 3: pop and accept in the same cycle
    ready_i = 1'b0; grant_vec_i = 32'h1 << 7;
    step();
    ready_i = 1'b1; grant_vec_i = 32'h1 << 20; #1;
    chk("t3_ack20", 64'(iq_ack_o), 64'h100000);
    chk("t3_idx7", 64'(idx_o), 64'd7);
    step();
    grant_vec_i = '0; ready_i = 1'b0; #1;
    chk("t3_valid", 64'(valid_o), 64'd1);
    chk("t3_idx20", 64'(idx_o), 64'd20);

    // 4: flush while full
    grant_vec_i = 32'h1 << 8;
    step();                                   // stall=3, count=2
    flush_i = 1'b1; grant_vec_i = 32'h1 << 4; #1;
    chk("t4_noack", 64'(iq_ack_o), 64'd0);
    chk("t4_gen_flush", 64'(grant_en_o), 64'd0);
    step();                                   // stall=4
    flush_i = 1'b0; grant_vec_i = '0; #1;
    chk("t4_valid", 64'(valid_o), 64'd0);
    chk("t4_gen", 64'(grant_en_o), 64'd1);
    chk("t4_stall", 64'(stall_cnt_o), 64'd4);

    // zero grant holds empty state
    step();
    chk("zero_hold", 64'(valid_o), 64'd0);
    chk("zero_ack", 64'(iq_ack_o), 64'd0);

    // 6: multi-hot grant, lowest bit wins
    grant_vec_i = 32'h11; #1;
    chk("t6_ack", 64'(iq_ack_o), 64'h11);
    step();
    grant_vec_i = '0; #1;
    chk("t6_idx0", 64'(idx_o), 64'd0);
    chk("t6_err", 64'(err_o), 64'(exp_err));
    step();                                   // stall=5
    chk("t6_err_sticky", 64'(err_o), 64'(exp_err));
    chk("t6_stall", 64'(stall_cnt_o), 64'd5);

    // 5: saturation of the stall counter
    for (int i = 0; i < 70000; i++) step();
    chk("t5_sat", 64'(stall_cnt_o), 64'hFFFF);
    step();
    chk("t5_sat_hold", 64'(stall_cnt_o), 64'hFFFF);
    chk("t5_err_sticky", 64'(err_o), 64'(exp_err));

    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("rst2_stall", 64'(stall_cnt_o), 64'd0);
    chk("rst2_err", 64'(err_o), 64'd0);
    chk("rst2_valid", 64'(valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
